playback_scheduler: RTL

PLAYBACK_SCHEDULER -- requirements
Module: playback_scheduler

---
 rtl/playback_scheduler_pkg.sv | 42 ++++
 rtl/playback_scheduler_if.sv | 29 ++
 rtl/tick_divider.sv | 37 +++
 rtl/playback_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/playback_scheduler_pkg.sv
// rtl/playback_scheduler_pkg.sv - shared memory word layout, FSM encoding and tempo codes
package playback_scheduler_pkg;

  // Default memory word geometry; word = {note, length}
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_MAX_DEPTH_BIT = 8;

  // Field positions inside a memory word
  localparam int NOTE_MSB = 15;
  localparam int NOTE_LSB = 8;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 0;

  // Tempo select codes; 11 behaves like 1x
  localparam logic [1:0] TEMPO_1X     = 2'b00;
  localparam logic [1:0] TEMPO_2X     = 2'b01;
  localparam logic [1:0] TEMPO_HALF   = 2'b10;
  localparam logic [1:0] TEMPO_1X_ALT = 2'b11;

  // Scheduler states; pause is a hold qualifier, not a state
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REWIND = 3'd1,
    ST_FETCH  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PLAY   = 3'd4,
    ST_GAP    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Counter width able to hold the longest possible load: 255 units at half tempo,
  // the note gap, or the read timeout, whichever is largest
  function automatic int cnt_width(input longint unit_ticks, input longint gap_ticks,
                                   input longint read_timeout);
    longint max_v;
    max_v = longint'(510) * unit_ticks;
    if (gap_ticks > max_v) max_v = gap_ticks;
    if (read_timeout > max_v) max_v = read_timeout;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/playback_scheduler_if.sv
// rtl/playback_scheduler_if.sv - song memory fetch bus between scheduler and memory unit
interface playback_scheduler_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_DEPTH_BIT = 8
);
  logic [DATA_WIDTH-1:0]    mem_data;
  logic                     mem_ready;
  logic [MAX_DEPTH_BIT-1:0] mem_duration;
  logic                     mem_read_en;
  logic                     mem_read_rst;

  // Scheduler side: issues fetches and rewinds, consumes words
  modport master (
    output mem_read_en,
    output mem_read_rst,
    input  mem_data,
    input  mem_ready,
    input  mem_duration
  );

  // Memory side: serves words and reports song length
  modport slave (
    input  mem_read_en,
    input  mem_read_rst,
    output mem_data,
    output mem_ready,
    output mem_duration
  );
endinterface

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - loadable, pausable down-counter shared by PLAY, GAP and read timeout
module tick_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over counting; counting stops at zero and while disabled
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/playback_scheduler.sv
// rtl/playback_scheduler.sv - song playback FSM: fetch note words, time notes and gaps, report done/fault
module playback_scheduler
  import playback_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MAX_DEPTH_BIT = DEF_MAX_DEPTH_BIT,
  parameter int UNIT_TICKS    = 6_250_000,
  parameter int GAP_TICKS     = 500_000,
  parameter int READ_TIMEOUT  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  input  logic [1:0]               tempo_sel,
  playback_scheduler_if.master     mem,
  output logic [7:0]               note_out,
  output logic                     note_valid,
  output logic [MAX_DEPTH_BIT-1:0] index,
  output logic                     busy,
  output logic                     done,
  output logic                     fault
);

  localparam int CW = cnt_width(longint'(UNIT_TICKS), longint'(GAP_TICKS),
                                longint'(READ_TIMEOUT));

  localparam logic [CW-1:0] UNIT_1X   = CW'(UNIT_TICKS);
  localparam logic [CW-1:0] UNIT_2X   = CW'(UNIT_TICKS >> 1);
  localparam logic [CW-1:0] UNIT_HALF = CW'(longint'(UNIT_TICKS) * 2);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS - 1);
  // The fetch cycle counts toward the read budget, so WAIT itself lasts READ_TIMEOUT-1 cycles
  localparam logic [CW-1:0] WAIT_LOAD = (READ_TIMEOUT >= 2) ? CW'(READ_TIMEOUT - 2) : '0;

  state_t                   state_q, state_d;
  logic [MAX_DEPTH_BIT-1:0] index_q, index_d;
  logic [7:0]               note_q, note_d;
  logic                     fault_q, fault_d;

  logic                     cnt_load;
  logic [CW-1:0]            cnt_load_val;
  logic                     cnt_en;
  logic                     cnt_zero;

  logic [DATA_WIDTH-1:0]    word;
  logic [7:0]               word_len;
  logic [CW-1:0]            unit_sel;
  logic [CW-1:0]            play_len;
  logic [MAX_DEPTH_BIT:0]   idx_inc;

  assign word     = mem.mem_data;
  assign word_len = word[LEN_MSB:LEN_LSB];
  assign idx_inc  = {1'b0, index_q} + (MAX_DEPTH_BIT + 1)'(1);

  // Note duration in clocks, using the tempo present at the moment the word is accepted
  always_comb begin
    unit_sel = UNIT_1X;
    case (tempo_sel)
      TEMPO_2X:   unit_sel = UNIT_2X;
      TEMPO_HALF: unit_sel = UNIT_HALF;
      default:    unit_sel = UNIT_1X;
    endcase
    play_len = CW'(word_len) * unit_sel;
  end

  // Timers only run in the timed states and freeze while paused
  assign cnt_en = !pause && ((state_q == ST_PLAY) || (state_q == ST_GAP) || (state_q == ST_WAIT));

  tick_divider #(
    .WIDTH (CW)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // Next-state and timer-load decisions; stop overrides every transition
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    note_d       = note_q;
    fault_d      = fault_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = (mem.mem_duration == '0) ? ST_DONE : ST_REWIND;
          end
        end
        ST_REWIND: begin
          index_d = '0;
          fault_d = 1'b0;
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (!pause) begin
            state_d      = ST_WAIT;
            cnt_load     = 1'b1;
            cnt_load_val = WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (mem.mem_ready) begin
            note_d   = word[NOTE_MSB:NOTE_LSB];
            cnt_load = 1'b1;
            if (play_len == '0) begin
              state_d      = ST_GAP;
              cnt_load_val = GAP_LOAD;
            end else begin
              state_d      = ST_PLAY;
              cnt_load_val = play_len - CW'(1);
            end
          end else if (!pause && cnt_zero) begin
            fault_d = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_PLAY: begin
          if (!pause && cnt_zero) begin
            state_d      = ST_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (!pause && cnt_zero) begin
            if (idx_inc == {1'b0, mem.mem_duration}) begin
              state_d = ST_DONE;
            end else begin
              index_d = idx_inc[MAX_DEPTH_BIT-1:0];
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, index, latched note and sticky fault registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      note_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      note_q  <= note_d;
      fault_q <= fault_d;
    end
  end

  assign mem.mem_read_en  = (state_q == ST_FETCH) && !pause && !stop;
  assign mem.mem_read_rst = (state_q == ST_REWIND) && !stop;

  assign note_out   = (state_q == ST_PLAY) ? note_q : 8'h00;
  assign note_valid = (state_q == ST_PLAY) && !pause;
  assign index      = index_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign fault      = fault_q;

endmodule
